// File: rtl/tag_match_cam_pkg.sv
// Shared constants and tag/index types for the tag CAM, issue-queue wakeup and LSQ.
package tag_match_cam_pkg;

  localparam int unsigned DEFAULT_ENTRIES   = 8;
  localparam int unsigned DEFAULT_TAG_WIDTH = 6;
  localparam int unsigned DEFAULT_IDX_WIDTH = $clog2(DEFAULT_ENTRIES);

  typedef logic [DEFAULT_TAG_WIDTH-1:0] tag_t;
  typedef logic [DEFAULT_IDX_WIDTH-1:0] idx_t;

endpackage

// File: rtl/tag_match_cam_eq_cmp.sv
// Combinational full-width equality comparator: per-bit XNOR, AND-reduced.
module eq_cmp #(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq
);

  always_comb begin
    eq = &(a ~^ b);
  end

endmodule

// File: rtl/tag_match_cam.sv
// Tag CAM: ENTRIES tags with valid bits; registered search result one cycle after srch_en.
module tag_match_cam
  import tag_match_cam_pkg::*;
#(
  parameter  int unsigned ENTRIES   = DEFAULT_ENTRIES,
  parameter  int unsigned TAG_WIDTH = DEFAULT_TAG_WIDTH,
  localparam int unsigned IDX_WIDTH = $clog2(ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IDX_WIDTH-1:0] wr_idx,
  input  logic [TAG_WIDTH-1:0] wr_tag,
  input  logic                 inv_en,
  input  logic [IDX_WIDTH-1:0] inv_idx,
  input  logic                 flush,
  input  logic                 srch_en,
  input  logic [TAG_WIDTH-1:0] srch_tag,
  output logic                 match_valid,
  output logic [ENTRIES-1:0]   match_vec,
  output logic                 match_any,
  output logic [IDX_WIDTH-1:0] match_idx,
  output logic [ENTRIES-1:0]   entry_valid
);

  logic [TAG_WIDTH-1:0] tags_q [ENTRIES];
  logic [TAG_WIDTH-1:0] tags_d [ENTRIES];
  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [ENTRIES-1:0]   eq;

  logic                 match_valid_q, match_valid_d;
  logic [ENTRIES-1:0]   match_vec_q,   match_vec_d;
  logic                 match_any_q,   match_any_d;
  logic [IDX_WIDTH-1:0] match_idx_q,   match_idx_d;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
    eq_cmp #(.WIDTH(TAG_WIDTH)) u_eq_cmp (
      .a  (tags_q[g]),
      .b  (srch_tag),
      .eq (eq[g])
    );
  end

  // Per-entry valid priority: flush > write > invalidate > hold.
  always_comb begin
    valid_d = valid_q;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      tags_d[i] = tags_q[i];
      if (inv_en && inv_idx == IDX_WIDTH'(i)) valid_d[i] = 1'b0;
      if (wr_en && wr_idx == IDX_WIDTH'(i)) begin
        valid_d[i] = 1'b1;
        tags_d[i]  = wr_tag;
      end
      if (flush) valid_d[i] = 1'b0;
    end
  end

  // Search uses pre-edge tags and valids, so same-cycle writes/flushes are not visible.
  always_comb begin
    match_valid_d = srch_en;
    match_vec_d   = srch_en ? (valid_q & eq) : '0;
    match_any_d   = |match_vec_d;
    match_idx_d   = '0;
    for (int unsigned i = ENTRIES; i > 0; i--) begin
      if (match_vec_d[i-1]) match_idx_d = IDX_WIDTH'(i - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      match_valid_q <= 1'b0;
      match_vec_q   <= '0;
      match_any_q   <= 1'b0;
      match_idx_q   <= '0;
    end else begin
      valid_q       <= valid_d;
      match_valid_q <= match_valid_d;
      match_vec_q   <= match_vec_d;
      match_any_q   <= match_any_d;
      match_idx_q   <= match_idx_d;
    end
  end

  // Tag storage carries no reset; contents are don't-care while invalid.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      tags_q[i] <= tags_d[i];
    end
  end

  assign match_valid = match_valid_q;
  assign match_vec   = match_vec_q;
  assign match_any   = match_any_q;
  assign match_idx   = match_idx_q;
  assign entry_valid = valid_q;

endmodule

// File: tb/tb_tag_match_cam.sv
// Directed bench for tag_match_cam: default 8x6 instance plus a 16x10 throughput instance.
module tb_tag_match_cam;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Default-parameter instance (8 entries, 6-bit tags)
  logic       rst, wr_en, inv_en, flush, srch_en;
  logic [2:0] wr_idx, inv_idx;
  logic [5:0] wr_tag, srch_tag;
  logic       match_valid, match_any;
  logic [7:0] match_vec, entry_valid;
  logic [2:0] match_idx;

  tag_match_cam u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag),
    .inv_en(inv_en), .inv_idx(inv_idx), .flush(flush), .srch_en(srch_en),
    .srch_tag(srch_tag), .match_valid(match_valid), .match_vec(match_vec),
    .match_any(match_any), .match_idx(match_idx), .entry_valid(entry_valid)
  );

  // Wide instance (16 entries, 10-bit tags)
  logic        b_wr_en, b_inv_en, b_flush, b_srch_en;
  logic [3:0]  b_wr_idx, b_inv_idx;
  logic [9:0]  b_wr_tag, b_srch_tag;
  logic        b_match_valid, b_match_any;
  logic [15:0] b_match_vec, b_entry_valid;
  logic [3:0]  b_match_idx;

  tag_match_cam #(.ENTRIES(16), .TAG_WIDTH(10)) u_dut_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_idx(b_wr_idx), .wr_tag(b_wr_tag),
    .inv_en(b_inv_en), .inv_idx(b_inv_idx), .flush(b_flush), .srch_en(b_srch_en),
    .srch_tag(b_srch_tag), .match_valid(b_match_valid), .match_vec(b_match_vec),
    .match_any(b_match_any), .match_idx(b_match_idx), .entry_valid(b_entry_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic v, input logic [7:0] vec,
                         input logic any, input logic [2:0] idx);
    chk({tag, ".valid"}, 32'(match_valid), 32'(v));
    chk({tag, ".vec"},   32'(match_vec),   32'(vec));
    chk({tag, ".any"},   32'(match_any),   32'(any));
    chk({tag, ".idx"},   32'(match_idx),   32'(idx));
  endtask

  task automatic idle();
    wr_en = 1'b0; inv_en = 1'b0; flush = 1'b0; srch_en = 1'b0;
    wr_idx = '0; inv_idx = '0; wr_tag = '0; srch_tag = '0;
  endtask

  initial begin
    logic [9:0] t;
    int e;

    idle();
    b_wr_en = 1'b0; b_inv_en = 1'b0; b_flush = 1'b0; b_srch_en = 1'b0;
    b_wr_idx = '0; b_inv_idx = '0; b_wr_tag = '0; b_srch_tag = '0;

    // Reset with a search pending: reset dominates
    rst = 1'b1; srch_en = 1'b1; srch_tag = 6'h00;
    tick(); tick();
    chk_res("reset", 1'b0, 8'h00, 1'b0, 3'd0);
    chk("reset.entry_valid", 32'(entry_valid), 32'h00);
    chk("reset.b_entry_valid", 32'(b_entry_valid), 32'h0000);

    rst = 1'b0;
    tick();
    chk_res("post_reset_srch0", 1'b1, 8'h00, 1'b0, 3'd0);

    // Basic hit / miss
    idle(); wr_en = 1'b1; wr_idx = 3'd2; wr_tag = 6'h15; tick();
    wr_idx = 3'd5; wr_tag = 6'h2A; tick();
    idle(); srch_en = 1'b1; srch_tag = 6'h2A; tick();
    chk_res("hit_2A", 1'b1, 8'h20, 1'b1, 3'd5);
    srch_tag = 6'h3F; tick();
    chk_res("miss_3F", 1'b1, 8'h00, 1'b0, 3'd0);
    srch_tag = 6'h15; tick();
    chk_res("hit_15", 1'b1, 8'h04, 1'b1, 3'd2);
    idle(); tick();
    chk_res("no_srch", 1'b0, 8'h00, 1'b0, 3'd0);

    // Duplicates: lowest index wins
    wr_en = 1'b1; wr_tag = 6'h07;
    wr_idx = 3'd6; tick();
    wr_idx = 3'd3; tick();
    wr_idx = 3'd7; tick();
    idle(); srch_en = 1'b1; srch_tag = 6'h07; tick();
    chk_res("dup_07", 1'b1, 8'hC8, 1'b1, 3'd3);
    chk("dup.entry_valid", 32'(entry_valid), 32'hEC);

    // Write and search same cycle: search sees old contents
    idle(); wr_en = 1'b1; wr_idx = 3'd1; wr_tag = 6'h11; srch_en = 1'b1; srch_tag = 6'h11; tick();
    chk_res("wr_srch_same", 1'b1, 8'h00, 1'b0, 3'd0);
    idle(); srch_en = 1'b1; srch_tag = 6'h11; tick();
    chk_res("wr_srch_next", 1'b1, 8'h02, 1'b1, 3'd1);

    // Write beats invalidate on the same index
    idle(); wr_en = 1'b1; wr_idx = 3'd4; wr_tag = 6'h22; inv_en = 1'b1; inv_idx = 3'd4; tick();
    chk("wr_inv_same.entry_valid", 32'(entry_valid), 32'hFE);
    // Write and invalidate on different indices both take effect
    idle(); wr_en = 1'b1; wr_idx = 3'd0; wr_tag = 6'h01; inv_en = 1'b1; inv_idx = 3'd2; tick();
    chk("wr_inv_diff.entry_valid", 32'(entry_valid), 32'hFB);
    idle(); srch_en = 1'b1; srch_tag = 6'h22; tick();
    chk_res("hit_22", 1'b1, 8'h10, 1'b1, 3'd4);
    srch_tag = 6'h15; tick();
    chk_res("inv_miss_15", 1'b1, 8'h00, 1'b0, 3'd0);

    // Flush beats write; same-cycle search uses pre-flush valids
    idle(); flush = 1'b1; wr_en = 1'b1; wr_idx = 3'd0; wr_tag = 6'h07;
    srch_en = 1'b1; srch_tag = 6'h07; tick();
    chk("flush_wr.entry_valid", 32'(entry_valid), 32'h00);
    chk_res("flush_srch", 1'b1, 8'hC8, 1'b1, 3'd3);

    // Fill all entries, invalidate entry 0, then flush
    idle(); wr_en = 1'b1; wr_tag = 6'h09;
    for (int i = 0; i < 8; i++) begin
      wr_idx = 3'(i); tick();
    end
    chk("fill.entry_valid", 32'(entry_valid), 32'hFF);
    idle(); inv_en = 1'b1; inv_idx = 3'd0; tick();
    idle(); srch_en = 1'b1; srch_tag = 6'h09; tick();
    chk_res("inv0_srch", 1'b1, 8'hFE, 1'b1, 3'd1);
    // Invalidating an already invalid entry changes nothing
    idle(); inv_en = 1'b1; inv_idx = 3'd0; tick();
    chk("inv_again.entry_valid", 32'(entry_valid), 32'hFE);
    idle(); flush = 1'b1; tick();
    chk("flush.entry_valid", 32'(entry_valid), 32'h00);
    idle(); srch_en = 1'b1; srch_tag = 6'h09; tick();
    chk_res("flush_miss", 1'b1, 8'h00, 1'b0, 3'd0);

    // Overwrite a valid entry's tag
    idle(); wr_en = 1'b1; wr_idx = 3'd3; wr_tag = 6'h09; tick();
    wr_tag = 6'h0A; tick();
    idle(); srch_en = 1'b1; srch_tag = 6'h09; tick();
    chk_res("ovr_old", 1'b1, 8'h00, 1'b0, 3'd0);
    srch_tag = 6'h0A; tick();
    chk_res("ovr_new", 1'b1, 8'h08, 1'b1, 3'd3);
    // Single-bit-different key must miss (full-width compare)
    srch_tag = 6'h2A; tick();
    chk_res("msb_diff", 1'b1, 8'h00, 1'b0, 3'd0);

    // Reset dominates a write in the same cycle
    idle(); rst = 1'b1; wr_en = 1'b1; wr_idx = 3'd5; wr_tag = 6'h01; srch_en = 1'b1; tick();
    chk("rst_wr.entry_valid", 32'(entry_valid), 32'h00);
    chk("rst_wr.match_valid", 32'(match_valid), 32'h0);
    rst = 1'b0; idle();

    // Wide instance: fill 16 entries with tag(i) = i*61+5, then 16 back-to-back searches
    b_wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b_wr_idx = 4'(i); b_wr_tag = 10'(i * 61 + 5); tick();
    end
    b_wr_en = 1'b0;
    chk("b_fill.entry_valid", 32'(b_entry_valid), 32'hFFFF);
    b_srch_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      e = (k * 5 + 3) % 16;
      t = 10'(e * 61 + 5);
      b_srch_tag = t;
      tick();
      chk($sformatf("b_srch%0d.valid", k), 32'(b_match_valid), 32'h1);
      chk($sformatf("b_srch%0d.idx", k),   32'(b_match_idx),   32'(e));
      chk($sformatf("b_srch%0d.vec", k),   32'(b_match_vec),   32'(1) << e);
    end
    b_srch_en = 1'b0; tick();
    chk("b_idle.valid", 32'(b_match_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_match_cam.md
Name: tag_match_cam

Overview:
- Parametrised content-addressable tag store for the OOO core. It holds ENTRIES tags of TAG_WIDTH bits, each with a valid bit.
- A search compares a key against all valid entries. It returns a registered hit vector, an any-hit flag and the lowest-index hit, one cycle later.
- Used by issue-queue wakeup and LSQ address matching.
- Supersedes fixed-width equality compare with width/depth generality, storage, invalidation, flush and pipelined results.

Parameters:
- ENTRIES, 8, number of tag entries (power of two, >= 2).
- TAG_WIDTH, 6, bits per tag/key.
- IDX_WIDTH, $clog2(ENTRIES), derived index width; not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write tag into entry wr_idx, set its valid.
- wr_idx  in  IDX_WIDTH  write index.
- wr_tag  in  TAG_WIDTH  tag written.
- inv_en  in  1  clear valid of entry inv_idx.
- inv_idx  in  IDX_WIDTH  invalidate index.
- flush  in  1  clear all valid bits.
- srch_en  in  1  search request.
- srch_tag  in  TAG_WIDTH  search key.
- match_valid  out  1  result registers hold a search result.
- match_vec  out  ENTRIES  per-entry hit (valid & tag==key).
- match_any  out  1  OR of match_vec.
- match_idx  out  IDX_WIDTH  lowest index set in match_vec; 0 when match_any=0.
- entry_valid  out  ENTRIES  current valid bits (debug/occupancy).

Behaviour:
- Reset (rst=1 at posedge): all valid bits=0, match_valid=0, match_vec=0, match_any=0, match_idx=0. Tag storage is not reset; it is don't-care while invalid.
- Reset dominates every other input in the same cycle.
- Search latency is 1 cycle. Compare happens combinationally in cycle N against pre-edge state; results register at the end of N and are visible in N+1.
- match_valid(N+1)=srch_en(N). When srch_en=0, match_vec/match_any/match_idx register to 0.
- Pipelined: back-to-back searches every cycle, no stall, no backpressure.
- Write and search in the same cycle: the search sees old contents. No write-through bypass.
- Per entry, next valid priority: flush > write > invalidate > hold.
  - flush with wr_en: entry stays invalid.
  - wr_en and inv_en to the same index: entry ends valid with wr_tag.
  - wr_en and inv_en to different indices: both take effect.
- Write to an already valid entry overwrites the tag; valid stays 1.
- Invalidate of an already invalid entry has no effect.
- Flush with search in the same cycle: the search uses pre-flush valids and its result still returns in N+1.
- Duplicate tags are legal. match_vec shows all hits; match_idx is the lowest index.
- No match, or all entries invalid: match_any=0, match_idx=0, match_vec=0.
- wr_idx/inv_idx are always in range (ENTRIES is a power of two).
- Equality is full TAG_WIDTH bitwise compare: XNOR per bit, AND-reduce.

Decomposition:
- Shared package holds the default ENTRIES/TAG_WIDTH constants and the tag_t/idx_t typedefs used by issue queue and LSQ.
- One sub-module: eq_cmp #(WIDTH), a parametrised combinational equality comparator (XNOR + AND-reduce), instantiated ENTRIES times.
- Lowest-index priority encoder stays inline.

Test Plan:
- Reset: assert rst with srch_en=1, tag 0 -> next cycle match_valid=0, entry_valid=0. Search key 0x00 after reset -> match_any=0, match_vec=0.
- Basic hit: write 0x15@2, 0x2A@5; search 0x2A -> one cycle later match_valid=1, match_vec=8'b0010_0000, match_idx=5, match_any=1. Search 0x3F -> match_any=0, match_idx=0.
- Duplicates/priority: write 0x07@6, 0x07@3, 0x07@7; search 0x07 -> match_vec=8'b1100_1000, match_idx=3.
- Same-cycle hazards:
  - Write 0x11@1 with search 0x11 same cycle -> no hit. Repeat search next cycle -> hit idx 1.
  - wr_en and inv_en both @4 -> entry_valid[4]=1.
  - flush + wr_en@0 -> entry_valid=0.
- Invalidate/flush: fill all 8 entries with 0x09; inv_idx=0 -> search gives match_idx=1, vec=8'hFE. Then flush -> entry_valid=0 and search misses.
- Throughput/param: TAG_WIDTH=10, ENTRIES=16. Issue 16 consecutive searches of distinct written tags, one per cycle -> each result 1 cycle later with match_idx equal to that tag's entry, no bubbles.
